buffer_if_id_ex_mem: RTL and testbench
======================================

BUFFER_IF_ID_EX_MEM -- requirements
Module: buffer_if_id_ex_mem

Interface
REQ-001 The block SHALL have one parameter: W, default 32, datapath width of instruction, address and data words.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst_b, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port lock, input, 1, pipeline stall; 1 holds every register.
REQ-005 The block SHALL have IF/ID ports inst_if input W, halted_controller_if input 1, and their registered copies inst_id output W, halted_controller_id output 1.
REQ-006 The block SHALL have ID/EX W-bit inputs inst_addr_id, rs_data_id, rt_data_id, inst_id_out, imm_extend_id, with registered outputs inst_addr_ex, rs_data_ex, rt_data_ex, inst_ex_in, imm_extend_ex.
REQ-007 The block SHALL have ID/EX field inputs inst_50_id (6), inst_2016_id/inst_1511_id/inst_106_id (5 each), ALU_OP_id (5), destination_register_id (2), register_src_id (2), jea_id (26), with `_ex` outputs of equal width.
REQ-008 The block SHALL have ID/EX 1-bit inputs is_nop, ALU_src, we_memory, register_write, branch, jump, jump_register, pc_enable, cache_input_type, we_cache, set_dirty, set_valid, memory_address_type, is_word, halted_controller (each suffixed `_id`), with `_ex` outputs.
REQ-009 The block SHALL have EX/MEM W-bit inputs inst_addr_ex, inst_ex_out, ALU_result_ex, rt_data_ex, imm_extend_ex, with outputs inst_addr_mem, inst_mem_in, ALU_result_mem, rt_data_mem, imm_extend_mem.
REQ-010 The block SHALL have EX/MEM inputs rd_num_ex (5) and register_src_ex (2), with `_mem` outputs of equal width.
REQ-011 The block SHALL have EX/MEM 1-bit inputs register_write, we_cache, we_memory, cache_input_type, set_dirty, set_valid, memory_address_type, is_word, jump_register, jump, branch, zero, pc_enable, is_nop, halted_controller (each suffixed `_ex`), with `_mem` outputs.

Function
REQ-012 Each output SHALL be a register loaded from its corresponding input: one rising edge of latency, no combinational input-to-output path.
REQ-013 The three stages SHALL be independent registers; a value written into IF/ID does not reach ID/EX unless fed back externally.
REQ-014 With rst_b=1 and lock=0, every register SHALL capture its input on each rising edge.
REQ-015 With rst_b=1 and lock=1, every register in all three stages SHALL hold its value.
REQ-016 Stall SHALL be uniform across the three stages; there is no per-stage lock or flush input.
REQ-017 Multi-bit fields SHALL be copied bit-exact with no sign extension, truncation or reordering.
REQ-018 Outputs SHALL change only at rising clk edges; input changes between edges SHALL have no effect.

Reset
REQ-019 When rst_b=0 at a rising edge, every output of all three stages SHALL become 0, including all halted_controller and pc_enable outputs.
REQ-020 Exception to REQ-019: is_nop_ex and is_nop_mem SHALL reset to 1 so the reset pipeline holds bubbles.
REQ-021 Reset SHALL take priority over lock.
REQ-022 Reset SHALL be synchronous: asserting rst_b between edges SHALL leave outputs unchanged until the next rising edge.

Verification
REQ-023 rst_b=0 for one edge with all inputs 0xFFFFFFFF / all-ones -> every output 0 except is_nop_ex=is_nop_mem=1.
REQ-024 rst_b=1, lock=0, inst_if=0x8C220004, halted_controller_if=1 -> after one edge inst_id=0x8C220004, halted_controller_id=1; unchanged before the edge.
REQ-025 ID/EX capture: rs_data_id=0x11111111, jea_id=0x3FFFFFF, ALU_OP_id=5'b10101, we_cache_id=1 -> next edge rs_data_ex=0x11111111, jea_ex=0x3FFFFFF, ALU_OP_ex=5'b10101, we_cache_ex=1.
REQ-026 Stall: load known values, set lock=1, change every input for 3 edges -> all outputs keep the pre-lock values; release lock -> new values appear after one edge.
REQ-027 Reset during stall: lock=1 and rst_b=0 at an edge -> outputs cleared per REQ-019/020.
REQ-028 EX/MEM capture: ALU_result_ex=0xDEADBEEF, rd_num_ex=5'd31, zero_ex=1, register_src_ex=2'b10 -> next edge ALU_result_mem=0xDEADBEEF, rd_num_mem=31, zero_mem=1, register_src_mem=2'b10.

Source files
------------

// File: rtl/buffer_if_id_ex_mem_if.sv
// buffer_if_id_ex_mem_if: grouped IF/ID, ID/EX and EX/MEM pipeline register signals
interface buffer_if_id_ex_mem_if #(parameter int W = 32);
    // IF/ID stage
    logic [W-1:0] inst_if_i, inst_id_o;
    logic         halted_controller_if_i, halted_controller_id_o;
    // ID/EX stage words and fields
    logic [W-1:0] inst_addr_id_i, rs_data_id_i, rt_data_id_i, inst_id_out_i, imm_extend_id_i;
    logic [W-1:0] inst_addr_ex_o, rs_data_ex_o, rt_data_ex_o, inst_ex_in_o, imm_extend_ex_o;
    logic [5:0]   inst_50_id_i, inst_50_ex_o;
    logic [4:0]   inst_2016_id_i, inst_1511_id_i, inst_106_id_i, ALU_OP_id_i;
    logic [4:0]   inst_2016_ex_o, inst_1511_ex_o, inst_106_ex_o, ALU_OP_ex_o;
    logic [1:0]   destination_register_id_i, register_src_id_i;
    logic [1:0]   destination_register_ex_o, register_src_ex_o;
    logic [25:0]  jea_id_i, jea_ex_o;
    // ID/EX stage control bits
    logic is_nop_id_i, ALU_src_id_i, we_memory_id_i, register_write_id_i, branch_id_i;
    logic jump_id_i, jump_register_id_i, pc_enable_id_i, cache_input_type_id_i, we_cache_id_i;
    logic set_dirty_id_i, set_valid_id_i, memory_address_type_id_i, is_word_id_i, halted_controller_id_i;
    logic is_nop_ex_o, ALU_src_ex_o, we_memory_ex_o, register_write_ex_o, branch_ex_o;
    logic jump_ex_o, jump_register_ex_o, pc_enable_ex_o, cache_input_type_ex_o, we_cache_ex_o;
    logic set_dirty_ex_o, set_valid_ex_o, memory_address_type_ex_o, is_word_ex_o, halted_controller_ex_o;
    // EX/MEM stage words and fields
    logic [W-1:0] inst_addr_ex_i, inst_ex_out_i, ALU_result_ex_i, rt_data_ex_i, imm_extend_ex_i;
    logic [W-1:0] inst_addr_mem_o, inst_mem_in_o, ALU_result_mem_o, rt_data_mem_o, imm_extend_mem_o;
    logic [4:0]   rd_num_ex_i, rd_num_mem_o;
    logic [1:0]   register_src_ex_i, register_src_mem_o;
    // EX/MEM stage control bits
    logic register_write_ex_i, we_cache_ex_i, we_memory_ex_i, cache_input_type_ex_i, set_dirty_ex_i;
    logic set_valid_ex_i, memory_address_type_ex_i, is_word_ex_i, jump_register_ex_i, jump_ex_i;
    logic branch_ex_i, zero_ex_i, pc_enable_ex_i, is_nop_ex_i, halted_controller_ex_i;
    logic register_write_mem_o, we_cache_mem_o, we_memory_mem_o, cache_input_type_mem_o, set_dirty_mem_o;
    logic set_valid_mem_o, memory_address_type_mem_o, is_word_mem_o, jump_register_mem_o, jump_mem_o;
    logic branch_mem_o, zero_mem_o, pc_enable_mem_o, is_nop_mem_o, halted_controller_mem_o;

    modport slave (
        input  inst_if_i, halted_controller_if_i,
        output inst_id_o, halted_controller_id_o,
        input  inst_addr_id_i, rs_data_id_i, rt_data_id_i, inst_id_out_i, imm_extend_id_i,
        input  inst_50_id_i, inst_2016_id_i, inst_1511_id_i, inst_106_id_i, ALU_OP_id_i,
        input  destination_register_id_i, register_src_id_i, jea_id_i,
        input  is_nop_id_i, ALU_src_id_i, we_memory_id_i, register_write_id_i, branch_id_i,
        input  jump_id_i, jump_register_id_i, pc_enable_id_i, cache_input_type_id_i, we_cache_id_i,
        input  set_dirty_id_i, set_valid_id_i, memory_address_type_id_i, is_word_id_i, halted_controller_id_i,
        output inst_addr_ex_o, rs_data_ex_o, rt_data_ex_o, inst_ex_in_o, imm_extend_ex_o,
        output inst_50_ex_o, inst_2016_ex_o, inst_1511_ex_o, inst_106_ex_o, ALU_OP_ex_o,
        output destination_register_ex_o, register_src_ex_o, jea_ex_o,
        output is_nop_ex_o, ALU_src_ex_o, we_memory_ex_o, register_write_ex_o, branch_ex_o,
        output jump_ex_o, jump_register_ex_o, pc_enable_ex_o, cache_input_type_ex_o, we_cache_ex_o,
        output set_dirty_ex_o, set_valid_ex_o, memory_address_type_ex_o, is_word_ex_o, halted_controller_ex_o,
        input  inst_addr_ex_i, inst_ex_out_i, ALU_result_ex_i, rt_data_ex_i, imm_extend_ex_i,
        input  rd_num_ex_i, register_src_ex_i,
        input  register_write_ex_i, we_cache_ex_i, we_memory_ex_i, cache_input_type_ex_i, set_dirty_ex_i,
        input  set_valid_ex_i, memory_address_type_ex_i, is_word_ex_i, jump_register_ex_i, jump_ex_i,
        input  branch_ex_i, zero_ex_i, pc_enable_ex_i, is_nop_ex_i, halted_controller_ex_i,
        output inst_addr_mem_o, inst_mem_in_o, ALU_result_mem_o, rt_data_mem_o, imm_extend_mem_o,
        output rd_num_mem_o, register_src_mem_o,
        output register_write_mem_o, we_cache_mem_o, we_memory_mem_o, cache_input_type_mem_o, set_dirty_mem_o,
        output set_valid_mem_o, memory_address_type_mem_o, is_word_mem_o, jump_register_mem_o, jump_mem_o,
        output branch_mem_o, zero_mem_o, pc_enable_mem_o, is_nop_mem_o, halted_controller_mem_o
    );

    modport master (
        output inst_if_i, halted_controller_if_i,
        input  inst_id_o, halted_controller_id_o,
        output inst_addr_id_i, rs_data_id_i, rt_data_id_i, inst_id_out_i, imm_extend_id_i,
        output inst_50_id_i, inst_2016_id_i, inst_1511_id_i, inst_106_id_i, ALU_OP_id_i,
        output destination_register_id_i, register_src_id_i, jea_id_i,
        output is_nop_id_i, ALU_src_id_i, we_memory_id_i, register_write_id_i, branch_id_i,
        output jump_id_i, jump_register_id_i, pc_enable_id_i, cache_input_type_id_i, we_cache_id_i,
        output set_dirty_id_i, set_valid_id_i, memory_address_type_id_i, is_word_id_i, halted_controller_id_i,
        input  inst_addr_ex_o, rs_data_ex_o, rt_data_ex_o, inst_ex_in_o, imm_extend_ex_o,
        input  inst_50_ex_o, inst_2016_ex_o, inst_1511_ex_o, inst_106_ex_o, ALU_OP_ex_o,
        input  destination_register_ex_o, register_src_ex_o, jea_ex_o,
        input  is_nop_ex_o, ALU_src_ex_o, we_memory_ex_o, register_write_ex_o, branch_ex_o,
        input  jump_ex_o, jump_register_ex_o, pc_enable_ex_o, cache_input_type_ex_o, we_cache_ex_o,
        input  set_dirty_ex_o, set_valid_ex_o, memory_address_type_ex_o, is_word_ex_o, halted_controller_ex_o,
        output inst_addr_ex_i, inst_ex_out_i, ALU_result_ex_i, rt_data_ex_i, imm_extend_ex_i,
        output rd_num_ex_i, register_src_ex_i,
        output register_write_ex_i, we_cache_ex_i, we_memory_ex_i, cache_input_type_ex_i, set_dirty_ex_i,
        output set_valid_ex_i, memory_address_type_ex_i, is_word_ex_i, jump_register_ex_i, jump_ex_i,
        output branch_ex_i, zero_ex_i, pc_enable_ex_i, is_nop_ex_i, halted_controller_ex_i,
        input  inst_addr_mem_o, inst_mem_in_o, ALU_result_mem_o, rt_data_mem_o, imm_extend_mem_o,
        input  rd_num_mem_o, register_src_mem_o,
        input  register_write_mem_o, we_cache_mem_o, we_memory_mem_o, cache_input_type_mem_o, set_dirty_mem_o,
        input  set_valid_mem_o, memory_address_type_mem_o, is_word_mem_o, jump_register_mem_o, jump_mem_o,
        input  branch_mem_o, zero_mem_o, pc_enable_mem_o, is_nop_mem_o, halted_controller_mem_o
    );
endinterface

// File: rtl/buffer_if_id_ex_mem.sv
// buffer_if_id_ex_mem: IF/ID, ID/EX and EX/MEM pipeline registers with common stall and sync reset
module buffer_if_id_ex_mem #(
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    lock,
    buffer_if_id_ex_mem_if.slave    bus
);
    // Each stage is one flat vector; is_nop sits at bit 0 of ID/EX and EX/MEM so the bubble reset value is just 1
    localparam int IFID_N  = W + 1;
    localparam int IDEX_N  = 5 * W + 71;
    localparam int EXMEM_N = 5 * W + 22;

    logic [IFID_N-1:0]  ifid_in, ifid_d, ifid_q;
    logic [IDEX_N-1:0]  idex_in, idex_d, idex_q;
    logic [EXMEM_N-1:0] exmem_in, exmem_d, exmem_q;

    assign ifid_in = {bus.inst_if_i, bus.halted_controller_if_i};

    assign idex_in = {bus.inst_addr_id_i, bus.rs_data_id_i, bus.rt_data_id_i, bus.inst_id_out_i, bus.imm_extend_id_i,
                      bus.inst_50_id_i, bus.inst_2016_id_i, bus.inst_1511_id_i, bus.inst_106_id_i, bus.ALU_OP_id_i,
                      bus.destination_register_id_i, bus.register_src_id_i, bus.jea_id_i,
                      bus.ALU_src_id_i, bus.we_memory_id_i, bus.register_write_id_i, bus.branch_id_i,
                      bus.jump_id_i, bus.jump_register_id_i, bus.pc_enable_id_i, bus.cache_input_type_id_i,
                      bus.we_cache_id_i, bus.set_dirty_id_i, bus.set_valid_id_i, bus.memory_address_type_id_i,
                      bus.is_word_id_i, bus.halted_controller_id_i, bus.is_nop_id_i};

    assign exmem_in = {bus.inst_addr_ex_i, bus.inst_ex_out_i, bus.ALU_result_ex_i, bus.rt_data_ex_i, bus.imm_extend_ex_i,
                       bus.rd_num_ex_i, bus.register_src_ex_i,
                       bus.register_write_ex_i, bus.we_cache_ex_i, bus.we_memory_ex_i, bus.cache_input_type_ex_i,
                       bus.set_dirty_ex_i, bus.set_valid_ex_i, bus.memory_address_type_ex_i, bus.is_word_ex_i,
                       bus.jump_register_ex_i, bus.jump_ex_i, bus.branch_ex_i, bus.zero_ex_i,
                       bus.pc_enable_ex_i, bus.halted_controller_ex_i, bus.is_nop_ex_i};

    // Stall holds all three stages together; otherwise every stage loads its inputs
    always_comb begin
        ifid_d  = lock ? ifid_q  : ifid_in;
        idex_d  = lock ? idex_q  : idex_in;
        exmem_d = lock ? exmem_q : exmem_in;
    end

    // Reset wins over stall and clears everything except the two is_nop bubble flags
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            ifid_q  <= '0;
            idex_q  <= {{(IDEX_N-1){1'b0}}, 1'b1};
            exmem_q <= {{(EXMEM_N-1){1'b0}}, 1'b1};
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
        end
    end

    assign {bus.inst_id_o, bus.halted_controller_id_o} = ifid_q;

    assign {bus.inst_addr_ex_o, bus.rs_data_ex_o, bus.rt_data_ex_o, bus.inst_ex_in_o, bus.imm_extend_ex_o,
            bus.inst_50_ex_o, bus.inst_2016_ex_o, bus.inst_1511_ex_o, bus.inst_106_ex_o, bus.ALU_OP_ex_o,
            bus.destination_register_ex_o, bus.register_src_ex_o, bus.jea_ex_o,
            bus.ALU_src_ex_o, bus.we_memory_ex_o, bus.register_write_ex_o, bus.branch_ex_o,
            bus.jump_ex_o, bus.jump_register_ex_o, bus.pc_enable_ex_o, bus.cache_input_type_ex_o,
            bus.we_cache_ex_o, bus.set_dirty_ex_o, bus.set_valid_ex_o, bus.memory_address_type_ex_o,
            bus.is_word_ex_o, bus.halted_controller_ex_o, bus.is_nop_ex_o} = idex_q;

    assign {bus.inst_addr_mem_o, bus.inst_mem_in_o, bus.ALU_result_mem_o, bus.rt_data_mem_o, bus.imm_extend_mem_o,
            bus.rd_num_mem_o, bus.register_src_mem_o,
            bus.register_write_mem_o, bus.we_cache_mem_o, bus.we_memory_mem_o, bus.cache_input_type_mem_o,
            bus.set_dirty_mem_o, bus.set_valid_mem_o, bus.memory_address_type_mem_o, bus.is_word_mem_o,
            bus.jump_register_mem_o, bus.jump_mem_o, bus.branch_mem_o, bus.zero_mem_o,
            bus.pc_enable_mem_o, bus.halted_controller_mem_o, bus.is_nop_mem_o} = exmem_q;
endmodule

// File: tb/tb_buffer_if_id_ex_mem.sv
// tb_buffer_if_id_ex_mem: directed checks of capture, stall, reset and stage independence
module tb_buffer_if_id_ex_mem;
    localparam int W       = 32;
    localparam int IFID_N  = W + 1;
    localparam int IDEX_N  = 5 * W + 71;
    localparam int EXMEM_N = 5 * W + 22;

    logic clk = 1'b0;
    logic rst_b;
    logic lock;
    int   checks = 0;
    int   errors = 0;

    logic [IFID_N-1:0]  exp_ifid, hold_ifid;
    logic [IDEX_N-1:0]  exp_idex, hold_idex;
    logic [EXMEM_N-1:0] exp_exmem, hold_exmem;
    logic [IFID_N-1:0]  ifid_o;
    logic [IDEX_N-1:0]  idex_o;
    logic [EXMEM_N-1:0] exmem_o;

    buffer_if_id_ex_mem_if #(.W(W)) bus();

    buffer_if_id_ex_mem #(.W(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .lock  (lock),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed outputs, each at the same position as its input in the drive vectors below
    assign ifid_o = {bus.inst_id_o, bus.halted_controller_id_o};
    assign idex_o = {bus.inst_addr_ex_o, bus.rs_data_ex_o, bus.rt_data_ex_o, bus.inst_ex_in_o, bus.imm_extend_ex_o,
                     bus.inst_50_ex_o, bus.inst_2016_ex_o, bus.inst_1511_ex_o, bus.inst_106_ex_o, bus.ALU_OP_ex_o,
                     bus.destination_register_ex_o, bus.register_src_ex_o, bus.jea_ex_o,
                     bus.ALU_src_ex_o, bus.we_memory_ex_o, bus.register_write_ex_o, bus.branch_ex_o,
                     bus.jump_ex_o, bus.jump_register_ex_o, bus.pc_enable_ex_o, bus.cache_input_type_ex_o,
                     bus.we_cache_ex_o, bus.set_dirty_ex_o, bus.set_valid_ex_o, bus.memory_address_type_ex_o,
                     bus.is_word_ex_o, bus.halted_controller_ex_o, bus.is_nop_ex_o};
    assign exmem_o = {bus.inst_addr_mem_o, bus.inst_mem_in_o, bus.ALU_result_mem_o, bus.rt_data_mem_o, bus.imm_extend_mem_o,
                      bus.rd_num_mem_o, bus.register_src_mem_o,
                      bus.register_write_mem_o, bus.we_cache_mem_o, bus.we_memory_mem_o, bus.cache_input_type_mem_o,
                      bus.set_dirty_mem_o, bus.set_valid_mem_o, bus.memory_address_type_mem_o, bus.is_word_mem_o,
                      bus.jump_register_mem_o, bus.jump_mem_o, bus.branch_mem_o, bus.zero_mem_o,
                      bus.pc_enable_mem_o, bus.halted_controller_mem_o, bus.is_nop_mem_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every input from three vectors and remember them as the expected next-edge outputs
    task automatic drive_vec(input logic [IFID_N-1:0] a, input logic [IDEX_N-1:0] b, input logic [EXMEM_N-1:0] c);
        {bus.inst_if_i, bus.halted_controller_if_i} = a;
        {bus.inst_addr_id_i, bus.rs_data_id_i, bus.rt_data_id_i, bus.inst_id_out_i, bus.imm_extend_id_i,
         bus.inst_50_id_i, bus.inst_2016_id_i, bus.inst_1511_id_i, bus.inst_106_id_i, bus.ALU_OP_id_i,
         bus.destination_register_id_i, bus.register_src_id_i, bus.jea_id_i,
         bus.ALU_src_id_i, bus.we_memory_id_i, bus.register_write_id_i, bus.branch_id_i,
         bus.jump_id_i, bus.jump_register_id_i, bus.pc_enable_id_i, bus.cache_input_type_id_i,
         bus.we_cache_id_i, bus.set_dirty_id_i, bus.set_valid_id_i, bus.memory_address_type_id_i,
         bus.is_word_id_i, bus.halted_controller_id_i, bus.is_nop_id_i} = b;
        {bus.inst_addr_ex_i, bus.inst_ex_out_i, bus.ALU_result_ex_i, bus.rt_data_ex_i, bus.imm_extend_ex_i,
         bus.rd_num_ex_i, bus.register_src_ex_i,
         bus.register_write_ex_i, bus.we_cache_ex_i, bus.we_memory_ex_i, bus.cache_input_type_ex_i,
         bus.set_dirty_ex_i, bus.set_valid_ex_i, bus.memory_address_type_ex_i, bus.is_word_ex_i,
         bus.jump_register_ex_i, bus.jump_ex_i, bus.branch_ex_i, bus.zero_ex_i,
         bus.pc_enable_ex_i, bus.halted_controller_ex_i, bus.is_nop_ex_i} = c;
        exp_ifid  = a;
        exp_idex  = b;
        exp_exmem = c;
    endtask

    // Deterministic distinct-per-field pattern so swapped or shifted fields show up
    task automatic drive_pattern(input int unsigned seed);
        logic [511:0] big;
        logic [31:0]  x;
        x = seed * 32'h9E3779B9 + 32'h1234567;
        for (int i = 0; i < 16; i++) begin
            x = x * 32'd1103515245 + 32'd12345;
            big[i*32 +: 32] = x ^ {x[15:0], x[31:16]};
        end
        drive_vec(big[IFID_N-1:0], big[IFID_N +: IDEX_N], big[IFID_N+IDEX_N +: EXMEM_N]);
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        lock  = 1'b0;
        drive_vec('1, '1, '1);
        tick();
        checks++; if (ifid_o !== '0) begin errors++; $display("FAIL reset_ifid: got %h expected 0", ifid_o); end
        checks++; if (idex_o !== {{(IDEX_N-1){1'b0}}, 1'b1}) begin errors++; $display("FAIL reset_idex: got %h expected 1", idex_o); end
        checks++; if (exmem_o !== {{(EXMEM_N-1){1'b0}}, 1'b1}) begin errors++; $display("FAIL reset_exmem: got %h expected 1", exmem_o); end
        checks++; if (bus.is_nop_ex_o !== 1'b1 || bus.is_nop_mem_o !== 1'b1) begin errors++; $display("FAIL reset_is_nop: got %b%b expected 11", bus.is_nop_ex_o, bus.is_nop_mem_o); end
        checks++; if ({bus.halted_controller_id_o, bus.halted_controller_ex_o, bus.halted_controller_mem_o} !== 3'b000) begin errors++; $display("FAIL reset_halted: got %b%b%b expected 000", bus.halted_controller_id_o, bus.halted_controller_ex_o, bus.halted_controller_mem_o); end
        checks++; if ({bus.pc_enable_ex_o, bus.pc_enable_mem_o} !== 2'b00) begin errors++; $display("FAIL reset_pc_enable: got %b%b expected 00", bus.pc_enable_ex_o, bus.pc_enable_mem_o); end
    endtask

    task automatic test_if_id();
        @(negedge clk);
        rst_b = 1'b1;
        bus.inst_if_i = 32'h8C220004;
        bus.halted_controller_if_i = 1'b1;
        #1;
        checks++; if (bus.inst_id_o !== 32'h0) begin errors++; $display("FAIL ifid_before_edge: got %h expected 00000000", bus.inst_id_o); end
        tick();
        checks++; if (bus.inst_id_o !== 32'h8C220004) begin errors++; $display("FAIL ifid_inst: got %h expected 8c220004", bus.inst_id_o); end
        checks++; if (bus.halted_controller_id_o !== 1'b1) begin errors++; $display("FAIL ifid_halted: got %b expected 1", bus.halted_controller_id_o); end
    endtask

    task automatic test_id_ex();
        @(negedge clk);
        drive_vec('0, '0, '0);
        bus.rs_data_id_i = 32'h11111111;
        bus.jea_id_i     = 26'h3FFFFFF;
        bus.ALU_OP_id_i  = 5'b10101;
        bus.we_cache_id_i = 1'b1;
        tick();
        checks++; if (bus.rs_data_ex_o !== 32'h11111111) begin errors++; $display("FAIL idex_rs_data: got %h expected 11111111", bus.rs_data_ex_o); end
        checks++; if (bus.jea_ex_o !== 26'h3FFFFFF) begin errors++; $display("FAIL idex_jea: got %h expected 3ffffff", bus.jea_ex_o); end
        checks++; if (bus.ALU_OP_ex_o !== 5'b10101) begin errors++; $display("FAIL idex_alu_op: got %b expected 10101", bus.ALU_OP_ex_o); end
        checks++; if (bus.we_cache_ex_o !== 1'b1) begin errors++; $display("FAIL idex_we_cache: got %b expected 1", bus.we_cache_ex_o); end
        checks++; if (bus.rt_data_ex_o !== 32'h0 || bus.we_cache_mem_o !== 1'b0) begin errors++; $display("FAIL idex_neighbours: got rt=%h we_cache_mem=%b expected 0 0", bus.rt_data_ex_o, bus.we_cache_mem_o); end
    endtask

    task automatic test_ex_mem();
        @(negedge clk);
        drive_vec('0, '0, '0);
        bus.ALU_result_ex_i   = 32'hDEADBEEF;
        bus.rd_num_ex_i       = 5'd31;
        bus.zero_ex_i         = 1'b1;
        bus.register_src_ex_i = 2'b10;
        tick();
        checks++; if (bus.ALU_result_mem_o !== 32'hDEADBEEF) begin errors++; $display("FAIL exmem_alu_result: got %h expected deadbeef", bus.ALU_result_mem_o); end
        checks++; if (bus.rd_num_mem_o !== 5'd31) begin errors++; $display("FAIL exmem_rd_num: got %0d expected 31", bus.rd_num_mem_o); end
        checks++; if (bus.zero_mem_o !== 1'b1) begin errors++; $display("FAIL exmem_zero: got %b expected 1", bus.zero_mem_o); end
        checks++; if (bus.register_src_mem_o !== 2'b10) begin errors++; $display("FAIL exmem_register_src: got %b expected 10", bus.register_src_mem_o); end
        checks++; if (bus.is_nop_mem_o !== 1'b0 || bus.rs_data_ex_o !== 32'h0) begin errors++; $display("FAIL exmem_neighbours: got is_nop_mem=%b rs_ex=%h expected 0 0", bus.is_nop_mem_o, bus.rs_data_ex_o); end
    endtask

    task automatic test_full_capture();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_pattern(k + 1);
            tick();
            checks++; if (ifid_o !== exp_ifid) begin errors++; $display("FAIL full_ifid_%0d: got %h expected %h", k, ifid_o, exp_ifid); end
            checks++; if (idex_o !== exp_idex) begin errors++; $display("FAIL full_idex_%0d: got %h expected %h", k, idex_o, exp_idex); end
            checks++; if (exmem_o !== exp_exmem) begin errors++; $display("FAIL full_exmem_%0d: got %h expected %h", k, exmem_o, exp_exmem); end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive_pattern(40);
        tick();
        hold_ifid  = exp_ifid;
        hold_idex  = exp_idex;
        hold_exmem = exp_exmem;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lock = 1'b1;
            drive_pattern(50 + k);
            tick();
            checks++; if (ifid_o !== hold_ifid) begin errors++; $display("FAIL stall_ifid_%0d: got %h expected %h", k, ifid_o, hold_ifid); end
            checks++; if (idex_o !== hold_idex) begin errors++; $display("FAIL stall_idex_%0d: got %h expected %h", k, idex_o, hold_idex); end
            checks++; if (exmem_o !== hold_exmem) begin errors++; $display("FAIL stall_exmem_%0d: got %h expected %h", k, exmem_o, hold_exmem); end
        end
        @(negedge clk);
        lock = 1'b0;
        tick();
        checks++; if (ifid_o !== exp_ifid) begin errors++; $display("FAIL release_ifid: got %h expected %h", ifid_o, exp_ifid); end
        checks++; if (idex_o !== exp_idex) begin errors++; $display("FAIL release_idex: got %h expected %h", idex_o, exp_idex); end
        checks++; if (exmem_o !== exp_exmem) begin errors++; $display("FAIL release_exmem: got %h expected %h", exmem_o, exp_exmem); end
    endtask

    task automatic test_between_edges();
        @(negedge clk);
        drive_pattern(60);
        tick();
        hold_idex  = exp_idex;
        hold_exmem = exp_exmem;
        @(negedge clk);
        drive_pattern(61);
        #2;
        drive_pattern(62);
        rst_b = 1'b0;
        #1;
        checks++; if (idex_o !== hold_idex) begin errors++; $display("FAIL midcycle_idex: got %h expected %h", idex_o, hold_idex); end
        checks++; if (exmem_o !== hold_exmem) begin errors++; $display("FAIL midcycle_exmem: got %h expected %h", exmem_o, hold_exmem); end
        tick();
        checks++; if (idex_o !== {{(IDEX_N-1){1'b0}}, 1'b1}) begin errors++; $display("FAIL sync_reset_idex: got %h expected 1", idex_o); end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset_during_stall();
        @(negedge clk);
        drive_pattern(70);
        tick();
        @(negedge clk);
        lock  = 1'b1;
        rst_b = 1'b0;
        tick();
        checks++; if (ifid_o !== '0) begin errors++; $display("FAIL stall_reset_ifid: got %h expected 0", ifid_o); end
        checks++; if (idex_o !== {{(IDEX_N-1){1'b0}}, 1'b1}) begin errors++; $display("FAIL stall_reset_idex: got %h expected 1", idex_o); end
        checks++; if (exmem_o !== {{(EXMEM_N-1){1'b0}}, 1'b1}) begin errors++; $display("FAIL stall_reset_exmem: got %h expected 1", exmem_o); end
        @(negedge clk);
        rst_b = 1'b1;
        tick();
        checks++; if (exmem_o !== {{(EXMEM_N-1){1'b0}}, 1'b1}) begin errors++; $display("FAIL stall_after_reset_hold: got %h expected 1", exmem_o); end
        lock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_id();
        test_id_ex();
        test_ex_mem();
        test_full_capture();
        test_stall();
        test_between_edges();
        test_reset_during_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
